serial_parity_framer: RTL and testbench

Parametrised successor to the team's single-bit even-parity FSM. Accepts a serial bit stream in frames of DATA_W bits and runs in one of two modes. In generate mode it passes the data bits through and appends an even or odd parity bit. In check mode it consumes a received parity bit, compares it with the computed parity and flags mismatches. It sits between a serial source and a serialiser or deframer, using valid/ready on both sides.

---
 rtl/parity_pkg.sv | 14 +
 rtl/serial_out_slot.sv | 40 ++++
 rtl/serial_parity_framer.sv | 132 +++++++++++++
 tb/tb_serial_parity_framer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared encodings for the serial parity framer: FSM states and mode bits.
package parity_pkg;

   typedef enum logic {
      ST_DATA = 1'b0,
      ST_PAR  = 1'b1
   } state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
   localparam logic MODE_GEN = 1'b0;
   localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/serial_out_slot.sv
// One-deep valid/ready output register. A load and a downstream consume on the
// same edge are allowed, so the slot sustains one bit per cycle.
module serial_out_slot (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_load_bit,
   input  logic i_load_last,
   input  logic i_out_ready,
   output logic o_out_valid,
   output logic o_out_bit,
   output logic o_out_last,
   output logic o_slot_free
);

   logic r_valid;
   logic r_bit;
   logic r_last;

   assign o_slot_free = !r_valid || i_out_ready;
   assign o_out_valid = r_valid;
   assign o_out_bit   = r_bit;
   assign o_out_last  = r_last;

   // Load a new bit, drop the valid flag once consumed, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_bit   <= 1'b0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_bit   <= i_load_bit;
         r_last  <= i_load_last;
      end else if (i_out_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_parity_framer.sv
// Serial parity framer: passes DATA_W data bits through and appends (generate
// mode) or consumes and checks (check mode) one parity bit per frame.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_DATA | accepting data bits, accumulating parity, counting to DATA_W
//   ST_PAR  | emitting generated parity, or accepting received parity
module serial_parity_framer
   import parity_pkg::*;
#(
   parameter  int DATA_W = 8,
   localparam int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic in_bit,
   output logic in_ready,
   input  logic odd_sel,
   input  logic chk_en,
   output logic out_valid,
   output logic out_bit,
   output logic out_last,
   input  logic out_ready,
   output logic par_run,
   output logic frame_done,
   output logic par_err
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DATA_W - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_par_run;
   logic             r_odd_l;
   logic             r_chk_l;
   logic             r_frame_done;
   logic             r_par_err;

   logic w_slot_free;
   logic w_in_ready;
   logic w_gen_par;
   logic w_accept;
   logic w_last_data;
   logic w_frame_end;
   logic w_load;
   logic w_load_bit;
   logic w_load_last;

   assign w_accept    = in_valid && w_in_ready;
   assign w_last_data = (r_state == ST_DATA) && w_accept && (r_cnt == LP_LAST);
   assign w_frame_end = (r_state == ST_PAR) && (w_accept || w_gen_par);
   assign w_load      = w_accept || w_gen_par;
   assign w_load_bit  = w_gen_par ? (r_par_run ^ r_odd_l) : in_bit;
   assign w_load_last = (r_state == ST_PAR);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_DATA;
      else        r_state <= w_next_state;
   end

   // Next-state: leave DATA after the last data bit, leave PAR when the parity bit is loaded.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_DATA: if (w_last_data) w_next_state = ST_PAR;
         ST_PAR:  if (w_frame_end) w_next_state = ST_DATA;
         default: w_next_state = ST_DATA;
      endcase
   end

   // Handshake outputs: upstream is held off while the generated parity bit waits for the slot.
   always_comb begin
      w_in_ready = 1'b0;
      w_gen_par  = 1'b0;
      if (rst_n) begin
         case (r_state)
            ST_DATA: w_in_ready = w_slot_free;
            ST_PAR: begin
               if (r_chk_l == MODE_CHK) w_in_ready = w_slot_free;
               else                     w_gen_par  = w_slot_free;
            end
            default: w_in_ready = 1'b0;
         endcase
      end
   end

   // Bit counter, parity accumulator, frame-start mode latch and completion flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_par_run    <= 1'b0;
         r_odd_l      <= PAR_EVEN;
         r_chk_l      <= MODE_GEN;
         r_frame_done <= 1'b0;
         r_par_err    <= 1'b0;
      end else begin
         r_frame_done <= w_frame_end;
         r_par_err    <= w_frame_end && w_accept && (in_bit ^ r_par_run ^ r_odd_l);
         if ((r_state == ST_DATA) && w_accept) begin
            if (r_cnt == '0) begin
               r_odd_l <= odd_sel;
               r_chk_l <= chk_en;
            end
            r_par_run <= r_par_run ^ in_bit;
            r_cnt     <= w_last_data ? '0 : r_cnt + CNT_W'(1);
         end
         if (w_frame_end) r_par_run <= 1'b0;
      end
   end

   serial_out_slot u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load),
      .i_load_bit  (w_load_bit),
      .i_load_last (w_load_last),
      .i_out_ready (out_ready),
      .o_out_valid (out_valid),
      .o_out_bit   (out_bit),
      .o_out_last  (out_last),
      .o_slot_free (w_slot_free)
   );

   assign in_ready   = w_in_ready;
   assign par_run    = r_par_run;
   assign frame_done = r_frame_done;
   assign par_err    = r_par_err;

endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed bench for serial_parity_framer (DATA_W=8 instance plus a DATA_W=1 instance).
module tb_serial_parity_framer;

   logic clk;
   logic rst_n;
   logic in_valid, in_bit, in_ready, odd_sel, chk_en;
   logic out_valid, out_bit, out_last, out_ready;
   logic par_run, frame_done, par_err;

   logic d1_in_valid, d1_in_bit, d1_in_ready, d1_odd_sel, d1_chk_en;
   logic d1_out_valid, d1_out_bit, d1_out_last, d1_out_ready;
   logic d1_par_run, d1_frame_done, d1_par_err;

   int total = 0;
   int bad   = 0;

   serial_parity_framer #(.DATA_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .odd_sel(odd_sel), .chk_en(chk_en), .out_valid(out_valid), .out_bit(out_bit),
      .out_last(out_last), .out_ready(out_ready), .par_run(par_run),
      .frame_done(frame_done), .par_err(par_err)
   );

   serial_parity_framer #(.DATA_W(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_bit(d1_in_bit), .in_ready(d1_in_ready),
      .odd_sel(d1_odd_sel), .chk_en(d1_chk_en), .out_valid(d1_out_valid), .out_bit(d1_out_bit),
      .out_last(d1_out_last), .out_ready(d1_out_ready), .par_run(d1_par_run),
      .frame_done(d1_frame_done), .par_err(d1_par_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
      total++;
      if ({out_valid, out_bit, out_last, par_run, frame_done, par_err} !== 6'b000000) begin
         bad++; $display("FAIL reset_outputs: got %b want 000000",
                         {out_valid, out_bit, out_last, par_run, frame_done, par_err});
      end
      total++;
      if ({d1_out_valid, d1_in_ready} !== 2'b00) begin
         bad++; $display("FAIL reset_w1: got %b want 00", {d1_out_valid, d1_in_ready});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_gen_even();
      logic [7:0] d  = 8'h07;
      logic       pr = 1'b0;
      odd_sel = 1'b0; chk_en = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_bit = d[i];
         @(posedge clk); #1;
         pr = pr ^ d[i];
         total++;
         if ({out_valid, out_bit, out_last, par_run, frame_done} !== {1'b1, d[i], 1'b0, pr, 1'b0}) begin
            bad++; $display("FAIL gen_data bit%0d: got v/b/l/pr/fd=%b want %b", i,
                            {out_valid, out_bit, out_last, par_run, frame_done},
                            {1'b1, d[i], 1'b0, pr, 1'b0});
         end
      end
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL gen_par_in_ready: got %0b want 0", in_ready); end
      @(posedge clk); #1;
      total++;
      if ({out_valid, out_bit, out_last, frame_done, par_err, par_run} !== 6'b111100) begin
         bad++; $display("FAIL gen_even_parity: got v/b/l/fd/pe/pr=%b want 111100",
                         {out_valid, out_bit, out_last, frame_done, par_err, par_run});
      end
      @(posedge clk); #1;
      total++;
      if ({out_valid, frame_done} !== 2'b00) begin
         bad++; $display("FAIL gen_after_frame: got v/fd=%b want 00", {out_valid, frame_done});
      end
   endtask

   task automatic test_odd();
      logic [7:0] dat [2] = '{8'h07, 8'h00};
      logic       ep  [2] = '{1'b0, 1'b1};
      logic [7:0] d;
      out_ready = 1'b1;
      for (int f = 0; f < 2; f++) begin
         d = dat[f];
         for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_bit = d[i];
            odd_sel = (i == 0) ? 1'b1 : 1'(i % 2);
            chk_en  = (i == 0) ? 1'b0 : 1'(i % 2);
            @(posedge clk); #1;
            total++;
            if ({out_valid, out_bit, out_last} !== {1'b1, d[i], 1'b0}) begin
               bad++; $display("FAIL odd_data f%0d bit%0d: got %b want %b", f, i,
                               {out_valid, out_bit, out_last}, {1'b1, d[i], 1'b0});
            end
         end
         in_valid = 1'b0; odd_sel = 1'b0; chk_en = 1'b0;
         @(posedge clk); #1;
         total++;
         if ({out_valid, out_bit, out_last, frame_done, par_err} !== {1'b1, ep[f], 3'b110}) begin
            bad++; $display("FAIL odd_parity f%0d: got v/b/l/fd/pe=%b want %b", f,
                            {out_valid, out_bit, out_last, frame_done, par_err}, {1'b1, ep[f], 3'b110});
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_check();
      logic [7:0] d = 8'hB4;
      logic rx  [2] = '{1'b0, 1'b1};
      logic err [2] = '{1'b0, 1'b1};
      out_ready = 1'b1; odd_sel = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_bit = d[i];
            chk_en = (i == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            total++;
            if ({out_valid, out_bit, out_last} !== {1'b1, d[i], 1'b0}) begin
               bad++; $display("FAIL chk_data f%0d bit%0d: got %b want %b", f, i,
                               {out_valid, out_bit, out_last}, {1'b1, d[i], 1'b0});
            end
         end
         total++;
         if (in_ready !== 1'b1) begin bad++; $display("FAIL chk_par_in_ready f%0d: got %0b want 1", f, in_ready); end
         in_valid = 1'b1; in_bit = rx[f];
         @(posedge clk); #1;
         in_valid = 1'b0;
         total++;
         if ({out_valid, out_bit, out_last, frame_done, par_err} !== {1'b1, rx[f], 2'b11, err[f]}) begin
            bad++; $display("FAIL chk_result f%0d: got v/b/l/fd/pe=%b want %b", f,
                            {out_valid, out_bit, out_last, frame_done, par_err}, {1'b1, rx[f], 2'b11, err[f]});
         end
         @(posedge clk); #1;
         total++;
         if ({frame_done, par_err} !== 2'b00) begin
            bad++; $display("FAIL chk_pulse_width f%0d: got fd/pe=%b want 00", f, {frame_done, par_err});
         end
      end
   endtask

   task automatic test_backpressure();
      logic src [32];
      logic eb  [36];
      logic el  [36];
      logic p, stalled, sb, sl;
      int in_idx = 0, out_idx = 0, fd = 0, cyc = 0;
      for (int fr = 0; fr < 4; fr++) begin
         p = 1'b0;
         for (int j = 0; j < 8; j++) begin
            src[fr*8+j] = 1'($urandom_range(0, 1));
            p = p ^ src[fr*8+j];
            eb[fr*9+j] = src[fr*8+j];
            el[fr*9+j] = 1'b0;
         end
         eb[fr*9+8] = p;
         el[fr*9+8] = 1'b1;
      end
      odd_sel = 1'b0; chk_en = 1'b0; stalled = 1'b0; sb = 1'b0; sl = 1'b0;
      while (out_idx < 36 && cyc < 3000) begin
         out_ready = ($urandom_range(0, 99) < 30);
         in_valid  = (in_idx < 32);
         in_bit    = (in_idx < 32) ? src[in_idx] : 1'b0;
         #1;
         if (stalled) begin
            total++;
            if ({out_valid, out_bit, out_last} !== {1'b1, sb, sl}) begin
               bad++; $display("FAIL bp_hold cyc%0d: got %b want %b", cyc,
                               {out_valid, out_bit, out_last}, {1'b1, sb, sl});
            end
         end
         stalled = out_valid && !out_ready;
         sb = out_bit; sl = out_last;
         if (out_valid && out_ready) begin
            total++;
            if ({out_bit, out_last} !== {eb[out_idx], el[out_idx]}) begin
               bad++; $display("FAIL bp_stream pos%0d: got b/l=%b want %b", out_idx,
                               {out_bit, out_last}, {eb[out_idx], el[out_idx]});
            end
            out_idx++;
         end
         if (in_valid && in_ready) in_idx++;
         if (frame_done) fd++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++;
      if (out_idx != 36 || in_idx != 32) begin
         bad++; $display("FAIL bp_count: got out=%0d in=%0d want out=36 in=32", out_idx, in_idx);
      end
      total++;
      if (fd != 4) begin bad++; $display("FAIL bp_frame_done: got %0d want 4", fd); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [4:0] pre = 5'b01011;
      logic [7:0] d   = 8'h01;
      int fd = 0;
      odd_sel = 1'b0; chk_en = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_bit = pre[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst_n = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_in_ready: got %0b want 0", in_ready); end
      @(posedge clk); #1;
      total++;
      if ({out_valid, out_last, par_run, frame_done} !== 4'b0000) begin
         bad++; $display("FAIL rst_mid_clear: got v/l/pr/fd=%b want 0000",
                         {out_valid, out_last, par_run, frame_done});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_bit = d[i];
         @(posedge clk); #1;
         if (frame_done) fd++;
         total++;
         if ({out_valid, out_bit, out_last} !== {1'b1, d[i], 1'b0}) begin
            bad++; $display("FAIL rst_mid_data bit%0d: got %b want %b", i,
                            {out_valid, out_bit, out_last}, {1'b1, d[i], 1'b0});
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      if (frame_done) fd++;
      total++;
      if ({out_valid, out_bit, out_last} !== 3'b111) begin
         bad++; $display("FAIL rst_mid_parity: got v/b/l=%b want 111", {out_valid, out_bit, out_last});
      end
      @(posedge clk); #1;
      if (frame_done) fd++;
      total++;
      if (fd != 1) begin bad++; $display("FAIL rst_mid_frame_done: got %0d want 1", fd); end
   endtask

   task automatic test_data_w1();
      logic src [3] = '{1'b1, 1'b0, 1'b1};
      logic eb  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic el  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      int iidx = 0, oidx = 0, fd = 0, cyc = 0;
      d1_out_ready = 1'b1; d1_odd_sel = 1'b0; d1_chk_en = 1'b0;
      while (oidx < 6 && cyc < 40) begin
         d1_in_valid = (iidx < 3);
         d1_in_bit   = (iidx < 3) ? src[iidx] : 1'b0;
         #1;
         if (d1_out_valid) begin
            total++;
            if ({d1_out_bit, d1_out_last} !== {eb[oidx], el[oidx]}) begin
               bad++; $display("FAIL w1_stream pos%0d: got b/l=%b want %b", oidx,
                               {d1_out_bit, d1_out_last}, {eb[oidx], el[oidx]});
            end
            oidx++;
         end
         if (d1_frame_done) fd++;
         if (d1_in_valid && d1_in_ready) iidx++;
         @(posedge clk); #1;
         cyc++;
      end
      d1_in_valid = 1'b0;
      total++;
      if (oidx != 6) begin bad++; $display("FAIL w1_count: got %0d want 6", oidx); end
      total++;
      if (fd != 3) begin bad++; $display("FAIL w1_frame_done: got %0d want 3", fd); end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_bit = 1'b0; odd_sel = 1'b0; chk_en = 1'b0; out_ready = 1'b1;
      d1_in_valid = 1'b0; d1_in_bit = 1'b0; d1_odd_sel = 1'b0; d1_chk_en = 1'b0; d1_out_ready = 1'b1;
      test_reset();
      test_gen_even();
      test_odd();
      test_check();
      test_backpressure();
      test_reset_mid();
      test_data_w1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
